// File: rtl/axi_light_arbiter.sv
// N-master to 1-slave AXI-Light arbiter with round-robin grant.
// One transaction (read or write) is in flight at a time. The granted master's
// channels are muxed through to the slave purely from registered state/grant,
// so no combinational path runs from a master's valid to its ready through
// the arbitration logic.
module axi_light_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_WSTRB_WIDTH = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_resetn,
  // master side (master i occupies slice [i*W +: W])
  input  logic [NUM_MASTERS-1:0]                 i_m_awvalid,
  output logic [NUM_MASTERS-1:0]                 o_m_awready,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]  i_m_awaddr,
  input  logic [NUM_MASTERS*3-1:0]               i_m_awprot,
  input  logic [NUM_MASTERS-1:0]                 i_m_wvalid,
  output logic [NUM_MASTERS-1:0]                 o_m_wready,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]  i_m_wdata,
  input  logic [NUM_MASTERS*AXI_WSTRB_WIDTH-1:0] i_m_wstrb,
  output logic [NUM_MASTERS-1:0]                 o_m_bvalid,
  input  logic [NUM_MASTERS-1:0]                 i_m_bready,
  output logic [NUM_MASTERS*2-1:0]               o_m_bresp,
  input  logic [NUM_MASTERS-1:0]                 i_m_arvalid,
  output logic [NUM_MASTERS-1:0]                 o_m_arready,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]  i_m_araddr,
  input  logic [NUM_MASTERS*3-1:0]               i_m_arprot,
  output logic [NUM_MASTERS-1:0]                 o_m_rvalid,
  input  logic [NUM_MASTERS-1:0]                 i_m_rready,
  output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]  o_m_rdata,
  output logic [NUM_MASTERS*2-1:0]               o_m_rresp,
  // slave side
  output logic                                   o_s_awvalid,
  input  logic                                   i_s_awready,
  output logic [AXI_ADDR_WIDTH-1:0]              o_s_awaddr,
  output logic [2:0]                             o_s_awprot,
  output logic                                   o_s_wvalid,
  input  logic                                   i_s_wready,
  output logic [AXI_DATA_WIDTH-1:0]              o_s_wdata,
  output logic [AXI_WSTRB_WIDTH-1:0]             o_s_wstrb,
  input  logic                                   i_s_bvalid,
  output logic                                   o_s_bready,
  input  logic [1:0]                             i_s_bresp,
  output logic                                   o_s_arvalid,
  input  logic                                   i_s_arready,
  output logic [AXI_ADDR_WIDTH-1:0]              o_s_araddr,
  output logic [2:0]                             o_s_arprot,
  input  logic                                   i_s_rvalid,
  output logic                                   o_s_rready,
  input  logic [AXI_DATA_WIDTH-1:0]              i_s_rdata,
  input  logic [1:0]                             i_s_rresp,
  // status
  output logic [$clog2(NUM_MASTERS)-1:0]         o_grant_id,
  output logic                                   o_busy
);

  localparam int GW = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {S_IDLE, S_WREQ, S_WRESP, S_RREQ, S_RRESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [GW-1:0] r_rr;
  logic [GW-1:0] r_grant;
  logic          r_busy;
  logic          r_aw_done;
  logic          r_w_done;

  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_cand;
  logic          w_any_req;
  logic          w_pick_wr;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_wr_both;

  // Round-robin scan from r_rr; scanning backwards lets the nearest requester win.
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = '0;
    w_cand    = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_cand = GW'((int'(r_rr) + k) % NUM_MASTERS);
      if (i_m_awvalid[w_cand] | i_m_arvalid[w_cand]) begin
        w_any_req = 1'b1;
        w_pick    = w_cand;
      end
    end
    w_pick_wr = i_m_awvalid[w_pick];
  end

  assign w_aw_hs   = o_s_awvalid & i_s_awready;
  assign w_w_hs    = o_s_wvalid & i_s_wready;
  assign w_b_hs    = i_s_bvalid & o_s_bready;
  assign w_ar_hs   = o_s_arvalid & i_s_arready;
  assign w_r_hs    = i_s_rvalid & o_s_rready;
  assign w_wr_both = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; write wins over read for a master asserting both.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = w_pick_wr ? S_WREQ : S_RREQ;
      S_WREQ:  if (w_wr_both) w_state_next = S_WRESP;
      S_WRESP: if (w_b_hs)    w_state_next = S_IDLE;
      S_RREQ:  if (w_ar_hs)   w_state_next = S_RRESP;
      S_RRESP: if (w_r_hs)    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Grant, rr pointer, busy flag and per-channel completion flags.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rr      <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_rr    <= (w_pick == GW'(NUM_MASTERS - 1)) ? '0 : w_pick + 1'b1;
          end
        end
        S_WREQ: begin
          if (w_wr_both) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        S_WRESP: if (w_b_hs) r_busy <= 1'b0;
        S_RRESP: if (w_r_hs) r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Channel muxing driven only by registered state and grant.
  always_comb begin
    o_m_awready = '0;
    o_m_wready  = '0;
    o_m_bvalid  = '0;
    o_m_bresp   = '0;
    o_m_arready = '0;
    o_m_rvalid  = '0;
    o_m_rdata   = '0;
    o_m_rresp   = '0;
    o_s_awvalid = 1'b0;
    o_s_awaddr  = '0;
    o_s_awprot  = '0;
    o_s_wvalid  = 1'b0;
    o_s_wdata   = '0;
    o_s_wstrb   = '0;
    o_s_bready  = 1'b0;
    o_s_arvalid = 1'b0;
    o_s_araddr  = '0;
    o_s_arprot  = '0;
    o_s_rready  = 1'b0;
    case (r_state)
      S_WREQ: begin
        o_s_awvalid          = i_m_awvalid[r_grant] & ~r_aw_done;
        o_s_wvalid           = i_m_wvalid[r_grant] & ~r_w_done;
        o_s_awaddr           = i_m_awaddr[r_grant*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        o_s_awprot           = i_m_awprot[r_grant*3 +: 3];
        o_s_wdata            = i_m_wdata[r_grant*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        o_s_wstrb            = i_m_wstrb[r_grant*AXI_WSTRB_WIDTH +: AXI_WSTRB_WIDTH];
        o_m_awready[r_grant] = i_s_awready & ~r_aw_done;
        o_m_wready[r_grant]  = i_s_wready & ~r_w_done;
      end
      S_WRESP: begin
        o_s_bready                = i_m_bready[r_grant];
        o_m_bvalid[r_grant]       = i_s_bvalid;
        o_m_bresp[r_grant*2 +: 2] = i_s_bresp;
      end
      S_RREQ: begin
        o_s_arvalid          = i_m_arvalid[r_grant];
        o_s_araddr           = i_m_araddr[r_grant*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        o_s_arprot           = i_m_arprot[r_grant*3 +: 3];
        o_m_arready[r_grant] = i_s_arready;
      end
      S_RRESP: begin
        o_s_rready                                          = i_m_rready[r_grant];
        o_m_rvalid[r_grant]                                 = i_s_rvalid;
        o_m_rdata[r_grant*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_s_rdata;
        o_m_rresp[r_grant*2 +: 2]                           = i_s_rresp;
      end
      default: ;
    endcase
  end

  assign o_grant_id = r_grant;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_axi_light_arbiter.sv
// Bench for axi_light_arbiter with three masters, a behavioural slave and a
// transaction-level round-robin model of the expected grant order.
module tb_axi_light_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [N-1:0]    m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [N*AW-1:0] m_awaddr, m_araddr;
  logic [N*3-1:0]  m_awprot, m_arprot;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [N*2-1:0]  m_bresp, m_rresp;
  logic [N*DW-1:0] m_rdata;

  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [2:0]    s_awprot, s_arprot;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  logic [1:0]    grant_id;
  logic          busy;

  axi_light_arbiter #(.NUM_MASTERS(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_WSTRB_WIDTH(SW)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_m_awvalid(m_awvalid), .o_m_awready(m_awready), .i_m_awaddr(m_awaddr), .i_m_awprot(m_awprot),
    .i_m_wvalid(m_wvalid), .o_m_wready(m_wready), .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb),
    .o_m_bvalid(m_bvalid), .i_m_bready(m_bready), .o_m_bresp(m_bresp),
    .i_m_arvalid(m_arvalid), .o_m_arready(m_arready), .i_m_araddr(m_araddr), .i_m_arprot(m_arprot),
    .o_m_rvalid(m_rvalid), .i_m_rready(m_rready), .o_m_rdata(m_rdata), .o_m_rresp(m_rresp),
    .o_s_awvalid(s_awvalid), .i_s_awready(s_awready), .o_s_awaddr(s_awaddr), .o_s_awprot(s_awprot),
    .o_s_wvalid(s_wvalid), .i_s_wready(s_wready), .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb),
    .i_s_bvalid(s_bvalid), .o_s_bready(s_bready), .i_s_bresp(s_bresp),
    .o_s_arvalid(s_arvalid), .i_s_arready(s_arready), .o_s_araddr(s_araddr), .o_s_arprot(s_arprot),
    .i_s_rvalid(s_rvalid), .o_s_rready(s_rready), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
    .o_grant_id(grant_id), .o_busy(busy)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { int mst; int kind; logic [31:0] data; logic [1:0] resp; int gid; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  rsp_t log_q[$];
  rsp_t exp_q[$];
  wr_t  sl_wr_q[$];
  wr_t  exp_wr_q[$];

  // slave state
  logic        sl_have_aw, sl_have_w;
  wr_t         sl_cur;
  int          sl_aw_cnt, sl_w_cnt;
  int          mhs_cnt[N];
  bit          rnd_ready;

  // transaction-level model: at most one pending write and one pending read per master
  int          mdl_rr;
  bit          pw[N], pr[N];
  logic [31:0] pw_addr[N], pw_data[N], pr_addr[N];
  logic [3:0]  pw_strb[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_any();
    for (int i = 0; i < N; i++) if (pw[i] || pr[i]) return 1'b1;
    return 1'b0;
  endfunction

  // serve the first pending master found scanning from mdl_rr; its write goes before its read
  function automatic void model_arb_one();
    for (int k = 0; k < N; k++) begin
      int i;
      rsp_t e;
      wr_t w;
      i = (mdl_rr + k) % N;
      if (pw[i] || pr[i]) begin
        e.mst = i;
        e.gid = i;
        if (pw[i]) begin
          e.kind = 0; e.data = 32'h0; e.resp = pw_addr[i][3:2];
          w.addr = pw_addr[i]; w.data = pw_data[i]; w.strb = pw_strb[i];
          exp_wr_q.push_back(w);
          pw[i] = 1'b0;
        end else begin
          e.kind = 1; e.data = pr_addr[i]; e.resp = pr_addr[i][3:2];
          pr[i] = 1'b0;
        end
        exp_q.push_back(e);
        mdl_rr = (i + 1) % N;
        return;
      end
    end
  endfunction

  function automatic void model_drain();
    while (model_any()) model_arb_one();
  endfunction

  task automatic issue_write(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    m_awvalid[m] = 1'b1; m_awaddr[m*AW +: AW] = a; m_awprot[m*3 +: 3] = 3'(m);
    m_wvalid[m]  = 1'b1; m_wdata[m*DW +: DW] = d;  m_wstrb[m*SW +: SW] = st;
    pw[m] = 1'b1; pw_addr[m] = a; pw_data[m] = d; pw_strb[m] = st;
  endtask

  task automatic issue_read(input int m, input logic [31:0] a);
    m_arvalid[m] = 1'b1; m_araddr[m*AW +: AW] = a; m_arprot[m*3 +: 3] = 3'(m);
    pr[m] = 1'b1; pr_addr[m] = a;
  endtask

  // One clock: sample handshakes on the falling edge, update masters and slave after the rising edge.
  task automatic tick();
    logic [N-1:0] haw, hw, hb, har, hr;
    logic saw, sw, sb, sar, sr;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0] w_s;
    @(negedge clk);
    haw = m_awvalid & m_awready; hw = m_wvalid & m_wready; hb = m_bvalid & m_bready;
    har = m_arvalid & m_arready; hr = m_rvalid & m_rready;
    saw = s_awvalid & s_awready; sw = s_wvalid & s_wready; sb = s_bvalid & s_bready;
    sar = s_arvalid & s_arready; sr = s_rvalid & s_rready;
    aw_a = s_awaddr; w_d = s_wdata; w_s = s_wstrb; ar_a = s_araddr;
    for (int i = 0; i < N; i++) begin
      rsp_t r;
      if (haw[i] || hw[i] || hb[i] || har[i] || hr[i]) mhs_cnt[i]++;
      if (hb[i] || hr[i]) begin
        r.mst  = i;
        r.kind = hb[i] ? 0 : 1;
        r.data = hb[i] ? 32'h0 : m_rdata[i*DW +: DW];
        r.resp = hb[i] ? m_bresp[i*2 +: 2] : m_rresp[i*2 +: 2];
        r.gid  = int'(grant_id);
        log_q.push_back(r);
        $display("[TB] txn m%0d %s data=0x%08h resp=%0d grant=%0d", i, hb[i] ? "WR" : "RD", r.data, r.resp, r.gid);
      end
    end
    @(posedge clk);
    #1;
    m_awvalid &= ~haw; m_wvalid &= ~hw; m_arvalid &= ~har;
    if (!resetn) begin
      s_bvalid = 1'b0; s_rvalid = 1'b0; sl_have_aw = 1'b0; sl_have_w = 1'b0;
    end else begin
      if (sb) s_bvalid = 1'b0;
      if (saw) begin sl_have_aw = 1'b1; sl_cur.addr = aw_a; sl_aw_cnt++; end
      if (sw)  begin sl_have_w = 1'b1; sl_cur.data = w_d; sl_cur.strb = w_s; sl_w_cnt++; end
      if (sl_have_aw && sl_have_w && !s_bvalid) begin
        sl_wr_q.push_back(sl_cur);
        s_bvalid = 1'b1; s_bresp = sl_cur.addr[3:2];
        sl_have_aw = 1'b0; sl_have_w = 1'b0;
      end
      if (sr) s_rvalid = 1'b0;
      if (sar) begin s_rvalid = 1'b1; s_rdata = ar_a; s_rresp = ar_a[3:2]; end
    end
    if (rnd_ready) begin
      s_awready = 1'($urandom_range(0, 1)); s_wready = 1'($urandom_range(0, 1));
      s_arready = 1'($urandom_range(0, 1));
      m_bready = 3'($urandom_range(0, 7)); m_rready = 3'($urandom_range(0, 7));
    end
    #1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin tick(); c++; end
    check("rsp_count", 64'(log_q.size()), 64'(n));
  endtask

  task automatic compare_all(input string tag);
    while (exp_q.size() > 0) begin
      rsp_t e, o;
      e = exp_q.pop_front();
      if (log_q.size() == 0) begin
        check($sformatf("%s_missing_m%0d", tag, e.mst), 64'(0), 64'(1));
      end else begin
        o = log_q.pop_front();
        check($sformatf("%s_mst", tag), 64'(o.mst), 64'(e.mst));
        check($sformatf("%s_kind_m%0d", tag, e.mst), 64'(o.kind), 64'(e.kind));
        check($sformatf("%s_data_m%0d", tag, e.mst), 64'(o.data), 64'(e.data));
        check($sformatf("%s_resp_m%0d", tag, e.mst), 64'(o.resp), 64'(e.resp));
        check($sformatf("%s_gid_m%0d", tag, e.mst), 64'(o.gid), 64'(e.gid));
      end
    end
    check($sformatf("%s_extra_rsp", tag), 64'(log_q.size()), 64'(0));
    check($sformatf("%s_wr_count", tag), 64'(sl_wr_q.size()), 64'(exp_wr_q.size()));
    while (exp_wr_q.size() > 0 && sl_wr_q.size() > 0) begin
      wr_t e, o;
      e = exp_wr_q.pop_front();
      o = sl_wr_q.pop_front();
      check($sformatf("%s_slv_awaddr", tag), 64'(o.addr), 64'(e.addr));
      check($sformatf("%s_slv_wdata", tag), 64'(o.data), 64'(e.data));
      check($sformatf("%s_slv_wstrb", tag), 64'(o.strb), 64'(e.strb));
    end
    exp_wr_q.delete();
    sl_wr_q.delete();
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_valids"}, 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
                                 m_awready, m_wready, m_arready, m_bvalid, m_rvalid}), 64'(0));
    check({tag, "_data"}, 64'(|{s_awaddr, s_awprot, s_wdata, s_wstrb, s_araddr, s_arprot,
                                m_bresp, m_rdata, m_rresp}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, w0, nrsp;
    logic [31:0] a;
    resetn = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '1; m_rready = '1;
    m_awaddr = '0; m_araddr = '0; m_awprot = '0; m_arprot = '0; m_wdata = '0; m_wstrb = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    s_bvalid = 1'b0; s_bresp = '0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    sl_have_aw = 1'b0; sl_have_w = 1'b0; sl_cur = '{default: '0};
    sl_aw_cnt = 0; sl_w_cnt = 0; rnd_ready = 1'b0; mdl_rr = 0;
    for (int i = 0; i < N; i++) begin mhs_cnt[i] = 0; pw[i] = 1'b0; pr[i] = 1'b0; end

    // reset held for 3 clocks, then idle with no requests
    repeat (3) tick();
    check_all_quiet("reset");
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_grant", 64'(grant_id), 64'(0));
    resetn = 1'b1;
    repeat (4) tick();
    check_all_quiet("idle");
    check("idle_busy", 64'(busy), 64'(0));

    // single write from master 1, slave ready immediately
    issue_write(1, 32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    check("idle_no_forward", 64'(s_awvalid), 64'(0));
    tick();
    check("w1_awvalid", 64'(s_awvalid), 64'(1));
    check("w1_awaddr", 64'(s_awaddr), 64'h100);
    check("w1_awprot", 64'(s_awprot), 64'(1));
    check("w1_wdata", 64'(s_wdata), 64'hDEADBEEF);
    check("w1_awready_vec", 64'(m_awready), 64'b010);
    check("w1_grant", 64'(grant_id), 64'(1));
    check("w1_busy", 64'(busy), 64'(1));
    model_drain();
    wait_log(1, 20);
    check("w1_no_hs_m0", 64'(mhs_cnt[0]), 64'(0));
    check("w1_no_hs_m2", 64'(mhs_cnt[2]), 64'(0));
    compare_all("w1");

    // three simultaneous reads after a reset pulse (rr back to 0)
    resetn = 1'b0; tick(); resetn = 1'b1; mdl_rr = 0; tick();
    for (int i = 0; i < N; i++) issue_read(i, ($urandom & 32'hFFFF_FFFC) | 32'(i << 2));
    model_drain();
    wait_log(3, 60);
    check("rd3_order0", 64'(log_q[0].gid), 64'(0));
    check("rd3_order1", 64'(log_q[1].gid), 64'(1));
    check("rd3_order2", 64'(log_q[2].gid), 64'(2));
    compare_all("rd3");

    // write with W accepted two clocks before AW
    s_awready = 1'b0;
    aw0 = sl_aw_cnt; w0 = sl_w_cnt;
    issue_write(0, $urandom & 32'hFFFF_FFFC, $urandom, 4'h3);
    model_drain();
    tick();
    check("wsplit_awvalid", 64'(s_awvalid), 64'(1));
    check("wsplit_wvalid", 64'(s_wvalid), 64'(1));
    tick();
    check("wsplit_w_once", 64'(s_wvalid), 64'(0));
    check("wsplit_not_wresp", 64'(s_bready), 64'(0));
    tick();
    check("wsplit_still_wreq", 64'({s_wvalid, s_bready, s_awvalid}), 64'b001);
    s_awready = 1'b1;
    tick();
    check("wsplit_aw_once", 64'(s_awvalid), 64'(0));
    check("wsplit_wresp", 64'(s_bready), 64'(1));
    wait_log(1, 20);
    check("wsplit_aw_count", 64'(sl_aw_cnt - aw0), 64'(1));
    check("wsplit_w_count", 64'(sl_w_cnt - w0), 64'(1));
    compare_all("wsplit");

    // master 2 write+read, master 1 joins after the first grant
    issue_write(2, $urandom & 32'hFFFF_FFF0, $urandom, 4'hC);
    issue_read(2, ($urandom & 32'hFFFF_FFF0) | 32'h8);
    model_arb_one();
    tick();
    check("wr2_grant", 64'(grant_id), 64'(2));
    issue_read(1, ($urandom & 32'hFFFF_FFF0) | 32'h4);
    model_drain();
    wait_log(3, 60);
    check("wr2_seq0", 64'(log_q[0].gid), 64'(2));
    check("wr2_seq1", 64'(log_q[1].gid), 64'(1));
    check("wr2_seq2", 64'(log_q[2].gid), 64'(2));
    compare_all("wr2");

    // reset while in the read response phase with s_rvalid high
    m_rready[0] = 1'b0;
    issue_read(0, 32'h0000_0A0C);
    tick(); tick(); tick();
    check("rrst_pending_rvalid", 64'(m_rvalid), 64'b001);
    check("rrst_pending_busy", 64'(busy), 64'(1));
    resetn = 1'b0;
    tick();
    check_all_quiet("rrst");
    check("rrst_busy", 64'(busy), 64'(0));
    check("rrst_grant", 64'(grant_id), 64'(0));
    pr[0] = 1'b0; mdl_rr = 0;
    m_rready[0] = 1'b1;
    resetn = 1'b1;
    tick();
    check("rrst_no_rsp", 64'(log_q.size()), 64'(0));
    issue_read(2, 32'h0000_2224);
    issue_read(0, 32'h0000_0008);
    model_drain();
    wait_log(2, 40);
    compare_all("rrst_after");

    // randomized batches with random slave/master readiness
    rnd_ready = 1'b1;
    for (int b = 0; b < 25; b++) begin
      nrsp = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          issue_write(i, $urandom, $urandom, 4'($urandom_range(0, 15))); nrsp++;
        end
        if ($urandom_range(0, 1) == 1) begin
          a = $urandom; issue_read(i, a); nrsp++;
        end
      end
      model_drain();
      wait_log(nrsp, 400);
      compare_all($sformatf("rnd%0d", b));
      tick();
    end
    rnd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_light_arbiter.md
Name: axi_light_arbiter

Overview:
- N-master to 1-slave arbiter for the AXI-Light bus.
- Shares one slave port (memory or peripheral) between several cores or DMA masters, with round-robin grant.
- Only one transaction is in flight at a time, read or write. The granted master's channels are muxed through to the slave. Responses return only to the granted master.
- Sits between the core-side if_axi_light master ports and the shared slave port.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width.
- AXI_WSTRB_WIDTH, 4, write strobe width (AXI_DATA_WIDTH/8).

Ports:
All m_* buses are flattened; master i occupies slice [i*W +: W].
- clk, in, 1, single clock; all logic on the rising edge.
- resetn, in, 1, synchronous active-low reset.
- m_awvalid, m_awready, in/out, NUM_MASTERS, per-master write-address handshake.
- m_awaddr, in, NUM_MASTERS*AXI_ADDR_WIDTH, write addresses.
- m_awprot, in, NUM_MASTERS*3.
- m_wvalid, m_wready, in/out, NUM_MASTERS, write-data handshake.
- m_wdata, in, NUM_MASTERS*AXI_DATA_WIDTH.
- m_wstrb, in, NUM_MASTERS*AXI_WSTRB_WIDTH.
- m_bvalid, m_bready, out/in, NUM_MASTERS, write-response handshake.
- m_bresp, out, NUM_MASTERS*2.
- m_arvalid, m_arready, in/out, NUM_MASTERS, read-address handshake.
- m_araddr, in, NUM_MASTERS*AXI_ADDR_WIDTH.
- m_arprot, in, NUM_MASTERS*3.
- m_rvalid, m_rready, out/in, NUM_MASTERS, read-response handshake.
- m_rdata, out, NUM_MASTERS*AXI_DATA_WIDTH.
- m_rresp, out, NUM_MASTERS*2.
- s_*, the same AXI-Light signal set toward the single slave, with directions mirrored (s_awvalid out, s_awready in, and so on).
- grant_id, out, clog2(NUM_MASTERS), index of the current owner; valid while busy=1.
- busy, out, 1, transaction in flight.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - FSM goes to IDLE and the rr pointer goes to 0.
  - Registered outputs clear: aw_done=w_done=0, grant_id=0, busy=0.
  - Combinational outputs follow: all valid/ready outputs (s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready, all m_*ready, m_bvalid, m_rvalid) are 0; data outputs are 0.
  - Reset mid-transaction abandons it with no response to the master. The slave must be reset with the same resetn.
- Request of master i: req_w[i]=m_awvalid[i]; req_r[i]=m_arvalid[i]; req[i]=req_w[i]|req_r[i].
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP.
- IDLE:
  - If any req, pick the first i with req[i]=1, scanning rr, rr+1, ... modulo NUM_MASTERS.
  - Register grant_id=i and set busy=1.
  - Go to WREQ if req_w[i], else RREQ. Write wins over read when one master asserts both.
  - Set rr=(i+1) mod NUM_MASTERS.
  - No outputs are forwarded in the IDLE cycle, so minimum arbitration latency is 1 clk.
- WREQ:
  - s_awvalid = m_awvalid[g] & ~aw_done; s_wvalid = m_wvalid[g] & ~w_done.
  - s_awaddr, s_awprot, s_wdata, s_wstrb come from slice g.
  - m_awready[g] = s_awready & ~aw_done; m_wready[g] likewise.
  - Set aw_done on s_awvalid&s_awready and w_done on s_wvalid&s_wready. AW and W may complete in either order or together.
  - When both are done (including the same cycle), clear the flags and go to WRESP.
- WRESP:
  - s_bready = m_bready[g]; m_bvalid[g] = s_bvalid; m_bresp[g] = s_bresp.
  - On s_bvalid & m_bready[g], go to IDLE and set busy=0.
- RREQ:
  - s_arvalid = m_arvalid[g]; s_araddr and s_arprot from slice g; m_arready[g] = s_arready.
  - On handshake, go to RRESP.
- RRESP:
  - s_rready = m_rready[g]; m_rvalid[g], m_rdata[g] and m_rresp[g] come from s_*.
  - On handshake, go to IDLE and set busy=0.
- Non-granted masters: all ready/valid outputs are held 0 and their requests wait. AXI requires masters to keep valid asserted until accepted, so no request is lost.
- Back-to-back: a master's new request is considered in the IDLE cycle after its response. The rr pointer guarantees that every other pending requester is served first, so starvation is bounded at NUM_MASTERS-1 transactions.
- All master→slave and slave→master paths are combinational muxes on registered grant_id/state. There are no combinational paths from m_*valid to m_*ready through arbitration.

Test Plan:
- NUM_MASTERS=3, reset held 3 clks → all s_*valid, m_*ready, m_bvalid, m_rvalid = 0; busy=0. After release with no requests, state stays IDLE.
- Master 1 writes addr 0x100, data 0xDEADBEEF, wstrb 0xF; slave awready=wready=1 immediately → s_awaddr=0x100 one clk after request. m_bvalid[1]=1 with bresp=0. Masters 0 and 2 see no handshake.
- Masters 0, 1, 2 all assert arvalid in the same cycle; slave returns rdata=addr → grants in order 0, 1, 2. Each master receives its own rdata; grant_id sequence is 0, 1, 2.
- Master 0 writes; slave asserts wready 2 clks before awready → exactly one AW and one W handshake at the slave. Only after both does state reach WRESP; no duplicate valid is forwarded.
- Master 2 asserts both awvalid and arvalid → write served first, then read on the next arbitration. Master 1 requesting meanwhile is granted between them per rr=0 scan order.
- Assert resetn=0 during RRESP with s_rvalid=1 → next clk all outputs 0, state IDLE, rr=0. After release, a new master 2 read completes normally.
